// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the writeback port arbiter: default widths,
// the requester payload record and the round-robin pick function.
package wb_arb_pkg;

    localparam int WB_PREG_W   = 6;
    localparam int WB_RESULT_W = 64;
    localparam int WB_PC_W     = 64;

    // rr_pick works on a fixed maximum vector; callers zero-extend.
    localparam int MAX_REQ  = 8;
    localparam int MAX_ID_W = 3;

    typedef struct packed {
        logic [WB_PREG_W-1:0]   prd;
        logic                   need_to_wb;
        logic [WB_RESULT_W-1:0] result;
        logic [WB_PC_W-1:0]     pc;
    } wb_req_t;

    typedef struct packed {
        logic                found;
        logic [MAX_ID_W-1:0] idx;
    } rr_pick_t;

    function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                         input logic [MAX_ID_W-1:0] ptr,
                                         input int n);
        rr_pick_t r;
        int       j;
        r = '0;
        // Walk offsets from farthest to nearest so the nearest valid wins.
        for (int k = MAX_REQ - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= n) j = j - n;
            if ((k < n) && valid[j[MAX_ID_W-1:0]]) begin
                r.found = 1'b1;
                r.idx   = j[MAX_ID_W-1:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/wb_port_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first valid requester at or after ptr,
// wrapping modulo NUM_REQ, returned as a one-hot grant plus index.
module rr_arbiter
    import wb_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [ID_W-1:0]    ptr,
    output logic               found,
    output logic [ID_W-1:0]    idx,
    output logic [NUM_REQ-1:0] grant
);

    rr_pick_t pick;

    always_comb begin
        pick  = rr_pick(MAX_REQ'(valid), MAX_ID_W'(ptr), NUM_REQ);
        found = pick.found;
        idx   = ID_W'(pick.idx);
        grant = '0;
        if (pick.found) grant[idx] = 1'b1;
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter sharing one writeback stage between NUM_REQ units,
// with a one-entry output slot. Optional perf counters: WB_ARB_PERF_EN.
module wb_port_arbiter
    import wb_arb_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int PREG_W   = WB_PREG_W,
    parameter int RESULT_W = WB_RESULT_W,
    parameter int PC_W     = WB_PC_W,
    parameter int ID_W     = $clog2(NUM_REQ)
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*PREG_W-1:0]    req_prd,
    input  logic [NUM_REQ-1:0]           req_need_to_wb,
    input  logic [NUM_REQ*RESULT_W-1:0]  req_result,
    input  logic [NUM_REQ*PC_W-1:0]      req_pc,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [PREG_W-1:0]            out_prd,
    output logic                         out_need_to_wb,
    output logic [RESULT_W-1:0]          out_result,
    output logic [PC_W-1:0]              out_pc,
    output logic [ID_W-1:0]              out_src_id,
`ifdef WB_ARB_PERF_EN
    output logic [31:0]                  perf_conflict_cnt,
    output logic [31:0]                  perf_stall_cnt,
`endif
    input  logic                         flush_valid
);

    logic               can_accept;
    logic               fire;
    logic               pick_found;
    logic [ID_W-1:0]    pick_idx;
    logic [NUM_REQ-1:0] pick_grant;
    logic [ID_W-1:0]    rr_ptr;

    logic                vld_p1;
    logic [PREG_W-1:0]   prd_p1;
    logic                ntw_p1;
    logic [RESULT_W-1:0] result_p1;
    logic [PC_W-1:0]     pc_p1;
    logic [ID_W-1:0]     src_p1;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr (
        .valid (req_valid),
        .ptr   (rr_ptr),
        .found (pick_found),
        .idx   (pick_idx),
        .grant (pick_grant)
    );

    // Stage p0: grant decision; the slot can refill in the cycle it drains.
    assign can_accept = ~flush_valid & (~vld_p1 | out_ready);
    assign fire       = pick_found & can_accept & ~reset;
    assign req_ready  = fire ? pick_grant : '0;

    // Stage p1: output slot and round-robin pointer.
    always_ff @(posedge clock) begin
        if (reset) begin
            vld_p1    <= 1'b0;
            prd_p1    <= '0;
            ntw_p1    <= 1'b0;
            result_p1 <= '0;
            pc_p1     <= '0;
            src_p1    <= '0;
            rr_ptr    <= '0;
        end else if (flush_valid) begin
            vld_p1    <= 1'b0;
            prd_p1    <= '0;
            ntw_p1    <= 1'b0;
            result_p1 <= '0;
            pc_p1     <= '0;
            src_p1    <= '0;
        end else if (fire) begin
            vld_p1    <= 1'b1;
            prd_p1    <= req_prd[pick_idx*PREG_W +: PREG_W];
            ntw_p1    <= req_need_to_wb[pick_idx];
            result_p1 <= req_result[pick_idx*RESULT_W +: RESULT_W];
            pc_p1     <= req_pc[pick_idx*PC_W +: PC_W];
            src_p1    <= pick_idx;
            rr_ptr    <= (pick_idx == ID_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
        end else if (vld_p1 & out_ready) begin
            vld_p1    <= 1'b0;
        end
    end

    assign out_valid      = vld_p1;
    assign out_prd        = prd_p1;
    assign out_need_to_wb = ntw_p1;
    assign out_result     = result_p1;
    assign out_pc         = pc_p1;
    assign out_src_id     = src_p1;

`ifdef WB_ARB_PERF_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] c);
        return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
    endfunction

    // Counters survive flush; only reset clears them.
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_conflict_cnt <= '0;
            perf_stall_cnt    <= '0;
        end else begin
            if (fire && ($countones(req_valid) > 1))
                perf_conflict_cnt <= sat_inc(perf_conflict_cnt);
            if (vld_p1 & ~out_ready)
                perf_stall_cnt <= sat_inc(perf_stall_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed vector table, hand sequences and a
// randomized run scored against a queue-based reference model.
module tb_wb_port_arbiter;
    import wb_arb_pkg::*;

    localparam int N  = 4;
    localparam int PW = WB_PREG_W;
    localparam int RW = WB_RESULT_W;
    localparam int CW = WB_PC_W;
    localparam int IW = 2;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [N-1:0]      req_valid = '0;
    logic [N-1:0]      req_ready;
    logic [N*PW-1:0]   req_prd = '0;
    logic [N-1:0]      req_need_to_wb = '0;
    logic [N*RW-1:0]   req_result = '0;
    logic [N*CW-1:0]   req_pc = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [PW-1:0]     out_prd;
    logic              out_need_to_wb;
    logic [RW-1:0]     out_result;
    logic [CW-1:0]     out_pc;
    logic [IW-1:0]     out_src_id;
    logic              flush_valid = 1'b0;
`ifdef WB_ARB_PERF_EN
    logic [31:0]       perf_conflict_cnt;
    logic [31:0]       perf_stall_cnt;
`endif

    wb_port_arbiter #(.NUM_REQ(N)) dut (
        .clock          (clock),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_prd        (req_prd),
        .req_need_to_wb (req_need_to_wb),
        .req_result     (req_result),
        .req_pc         (req_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_prd        (out_prd),
        .out_need_to_wb (out_need_to_wb),
        .out_result     (out_result),
        .out_pc         (out_pc),
        .out_src_id     (out_src_id),
`ifdef WB_ARB_PERF_EN
        .perf_conflict_cnt (perf_conflict_cnt),
        .perf_stall_cnt    (perf_stall_cnt),
`endif
        .flush_valid    (flush_valid)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    wb_req_t pay [N];

    function automatic wb_req_t fixed_pay(input int i);
        wb_req_t p;
        p.prd        = PW'(8'h13 + i);
        p.need_to_wb = i[0];
        p.result     = 64'hDEAD_BEED + 64'(i);
        p.pc         = 64'h8000_0000 + 64'(8 * i);
        return p;
    endfunction

    task automatic drive_pay();
        for (int i = 0; i < N; i++) begin
            req_prd[i*PW +: PW]    = pay[i].prd;
            req_need_to_wb[i]      = pay[i].need_to_wb;
            req_result[i*RW +: RW] = pay[i].result;
            req_pc[i*CW +: CW]     = pay[i].pc;
        end
    endtask

    task automatic chk_slot(input string tag, input wb_req_t e, input logic [IW-1:0] src);
        chk({tag, "_prd"},    out_prd,        e.prd);
        chk({tag, "_ntw"},    out_need_to_wb, e.need_to_wb);
        chk({tag, "_result"}, out_result,     e.result);
        chk({tag, "_pc"},     out_pc,         e.pc);
        chk({tag, "_src"},    out_src_id,     src);
    endtask

    typedef struct {
        logic [N-1:0]  v;
        logic          ordy;
        logic          fl;
        logic [N-1:0]  rdy;
        logic          vld;
        logic [IW-1:0] src;
    } vec_t;

    typedef struct packed {
        wb_req_t       p;
        logic [IW-1:0] src;
    } sb_t;

    vec_t tbl[$];
    sb_t  sb[$];

    initial begin
        logic [N-1:0] pend;
        int           waited [N];
        int           m_ptr;
        int           g;
        logic         found, can;
        logic [N-1:0] exp_rdy;

        for (int i = 0; i < N; i++) pay[i] = fixed_pay(i);
        drive_pay();

        // Expected values worked out by hand from the arbitration rules.
        for (int k = 0; k < 5; k++)
            tbl.push_back('{4'b1111, 1'b1, 1'b0, 4'(1 << (k % 4)), 1'b1, IW'(k % 4)});
        tbl.push_back('{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0});
        tbl.push_back('{4'b0100, 1'b1, 1'b0, 4'b0100, 1'b1, 2'd2});
        tbl.push_back('{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd2});
        tbl.push_back('{4'b1111, 1'b1, 1'b0, 4'b1000, 1'b1, 2'd3});
        for (int k = 0; k < 5; k++)
            tbl.push_back('{4'b0011, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd3});
        tbl.push_back('{4'b0011, 1'b1, 1'b0, 4'b0001, 1'b1, 2'd0});
        tbl.push_back('{4'b0010, 1'b1, 1'b1, 4'b0000, 1'b0, 2'd0});
        tbl.push_back('{4'b0010, 1'b1, 1'b0, 4'b0010, 1'b1, 2'd1});
        tbl.push_back('{4'b1111, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd0});
        tbl.push_back('{4'b1111, 1'b0, 1'b0, 4'b0100, 1'b1, 2'd2});

        // Reset with requests pending: nothing granted, slot empty.
        req_valid = 4'b1111;
        out_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_ready", req_ready, '0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_src", out_src_id, '0);
        chk("rst_prd", out_prd, '0);
        chk("rst_result", out_result, '0);
        chk("rst_pc", out_pc, '0);
        reset = 1'b0;

        foreach (tbl[r]) begin
            req_valid   = tbl[r].v;
            out_ready   = tbl[r].ordy;
            flush_valid = tbl[r].fl;
            #3;
            chk($sformatf("tbl%0d_ready", r), req_ready, tbl[r].rdy);
            @(posedge clock);
            #1;
            chk($sformatf("tbl%0d_out_valid", r), out_valid, tbl[r].vld);
            chk($sformatf("tbl%0d_src", r), out_src_id, tbl[r].src);
            if (tbl[r].vld)
                chk_slot($sformatf("tbl%0d", r), fixed_pay(int'(tbl[r].src)), tbl[r].src);
            if (tbl[r].fl)
                chk_slot($sformatf("tbl%0d_flushed", r), '0, '0);
        end
        flush_valid = 1'b0;

        // Reset while the slot is full drops it and rewinds the pointer.
        reset     = 1'b1;
        req_valid = 4'b1111;
        out_ready = 1'b1;
        #3;
        chk("rstmid_ready", req_ready, '0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        chk("rstmid_out_valid", out_valid, 1'b0);
        chk("rstmid_src", out_src_id, '0);
        #3;
        chk("rstmid_regrant", req_ready, 4'b0001);
        @(posedge clock);
        #1;
        chk("rstmid_out_valid2", out_valid, 1'b1);
        chk("rstmid_src2", out_src_id, '0);

`ifdef WB_ARB_PERF_EN
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset     = 1'b0;
        req_valid = 4'b0011;
        out_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        req_valid = 4'b0000;
        out_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("perf_conflict", perf_conflict_cnt, 32'd3);
        chk("perf_stall", perf_stall_cnt, 32'd2);
        req_valid   = 4'b0011;
        out_ready   = 1'b1;
        flush_valid = 1'b1;
        @(posedge clock);
        #1;
        flush_valid = 1'b0;
        req_valid   = 4'b0000;
        chk("perf_conflict_flush", perf_conflict_cnt, 32'd3);
        chk("perf_stall_flush", perf_stall_cnt, 32'd2);
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("perf_conflict_rst", perf_conflict_cnt, 32'd0);
        chk("perf_stall_rst", perf_stall_cnt, 32'd0);
`endif

        // Randomized run against the queue model.
        reset = 1'b1;
        req_valid = '0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        pend  = '0;
        m_ptr = 0;
        for (int i = 0; i < N; i++) waited[i] = 0;

        for (int cyc = 0; cyc < 1000; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && (i == 0 || $urandom_range(0, 2) == 0)) begin
                    pend[i]           = 1'b1;
                    waited[i]         = 0;
                    pay[i].prd        = PW'($urandom);
                    pay[i].need_to_wb = 1'($urandom_range(0, 1));
                    pay[i].result     = {$urandom, $urandom};
                    pay[i].pc         = {$urandom, $urandom};
                end
            end
            req_valid   = pend;
            drive_pay();
            out_ready   = ($urandom_range(0, 3) != 0);
            flush_valid = 1'b0;
            #3;

            found = 1'b0;
            g     = 0;
            for (int k = N - 1; k >= 0; k--) begin
                if (pend[(m_ptr + k) % N]) begin
                    found = 1'b1;
                    g     = (m_ptr + k) % N;
                end
            end
            can     = (sb.size() == 0) || out_ready;
            exp_rdy = (found && can) ? 4'(1 << g) : '0;
            chk("rnd_ready", req_ready, exp_rdy);
            chk("rnd_out_valid", out_valid, sb.size() != 0);
            if (sb.size() != 0 && out_valid)
                chk_slot("rnd_slot", sb[0].p, sb[0].src);
            if (sb.size() != 0 && out_ready)
                void'(sb.pop_front());
            if (found && can) begin
                chk($sformatf("rnd_fair_req%0d", g), (waited[g] < N), 1'b1);
                sb.push_back('{pay[g], IW'(g)});
                for (int j = 0; j < N; j++)
                    if (j != g && pend[j]) waited[j]++;
                pend[g] = 1'b0;
                m_ptr   = (g + 1) % N;
            end
            @(posedge clock);
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
